// File: rtl/if_id_stage_buffer.sv
// IF/ID pipeline buffer: a two-entry in-order FIFO between fetch and decode.
// The head entry is decoded combinationally into MIPS-style instruction fields.
module if_id_stage_buffer #(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_instruction,
    input  logic [DATA_W-1:0] in_pc,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_instruction,
    output logic [DATA_W-1:0] out_pc,
    output logic [DATA_W-1:0] out_pc_plus4,
    output logic [5:0]        out_opcode,
    output logic [4:0]        out_rs,
    output logic [4:0]        out_rt,
    output logic [4:0]        out_rd,
    output logic [4:0]        out_shamt,
    output logic [5:0]        out_funct,
    output logic [DATA_W-1:0] out_imm_sext,
    output logic [DATA_W-1:0] out_jump_target,
    output logic [15:0]       stall_count
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_t;

    state_t            state;
    logic [DATA_W-1:0] head_instr;
    logic [DATA_W-1:0] head_pc;
    logic [DATA_W-1:0] tail_instr;
    logic [DATA_W-1:0] tail_pc;
    logic              push;
    logic              pop;
    logic [DATA_W-1:0] vis_instr;
    logic [DATA_W-1:0] vis_pc;

    // Handshakes depend only on registered state, so out_ready never reaches in_ready.
    assign in_ready  = (state != FULL);
    assign out_valid = (state != EMPTY);
    assign push      = in_valid & in_ready;
    assign pop       = out_valid & out_ready;

    // Occupancy, entry storage and the saturating stall counter; flush empties the
    // buffer and suppresses every other update in that cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= EMPTY;
            head_instr  <= '0;
            head_pc     <= '0;
            tail_instr  <= '0;
            tail_pc     <= '0;
            stall_count <= '0;
        end else if (flush) begin
            state <= EMPTY;
        end else begin
            if (out_valid && !out_ready && stall_count != 16'hFFFF) begin
                stall_count <= stall_count + 16'd1;
            end
            case (state)
                EMPTY: begin
                    if (push) begin
                        head_instr <= in_instruction;
                        head_pc    <= in_pc;
                        state      <= ONE;
                    end
                end
                ONE: begin
                    if (push && pop) begin
                        head_instr <= in_instruction;
                        head_pc    <= in_pc;
                    end else if (push) begin
                        tail_instr <= in_instruction;
                        tail_pc    <= in_pc;
                        state      <= FULL;
                    end else if (pop) begin
                        state <= EMPTY;
                    end
                end
                FULL: begin
                    if (pop) begin
                        head_instr <= tail_instr;
                        head_pc    <= tail_pc;
                        state      <= ONE;
                    end
                end
                default: state <= EMPTY;
            endcase
        end
    end

    // Everything the decode stage sees is zero whenever no head entry is valid.
    assign vis_instr       = out_valid ? head_instr : '0;
    assign vis_pc          = out_valid ? head_pc : '0;
    assign out_instruction = vis_instr;
    assign out_pc          = vis_pc;
    assign out_pc_plus4    = out_valid ? vis_pc + 32'd4 : '0;
    assign out_opcode      = vis_instr[31:26];
    assign out_rs          = vis_instr[25:21];
    assign out_rt          = vis_instr[20:16];
    assign out_rd          = vis_instr[15:11];
    assign out_shamt       = vis_instr[10:6];
    assign out_funct       = vis_instr[5:0];
    assign out_imm_sext    = {{16{vis_instr[15]}}, vis_instr[15:0]};
    assign out_jump_target = out_valid ? {out_pc_plus4[31:28], vis_instr[25:0], 2'b00} : '0;

endmodule

// File: tb/tb_if_id_stage_buffer.sv
// Testbench for if_id_stage_buffer: directed vector table, hand-written corner
// sequences and random traffic checked against a queue-based reference model.
module tb_if_id_stage_buffer;

    logic        clk;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_instruction;
    logic [31:0] in_pc;
    logic        flush;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instruction;
    logic [31:0] out_pc;
    logic [31:0] out_pc_plus4;
    logic [5:0]  out_opcode;
    logic [4:0]  out_rs;
    logic [4:0]  out_rt;
    logic [4:0]  out_rd;
    logic [4:0]  out_shamt;
    logic [5:0]  out_funct;
    logic [31:0] out_imm_sext;
    logic [31:0] out_jump_target;
    logic [15:0] stall_count;

    int compared   = 0;
    int mismatched = 0;

    typedef struct {
        logic [31:0] instr;
        logic [31:0] pc;
    } entry_t;

    entry_t      model_q[$];
    int unsigned model_stall;

    typedef struct {
        logic        rst;
        logic        iv;
        logic [31:0] instr;
        logic [31:0] pc;
        logic        fl;
        logic        ordy;
        logic        exp_valid;
        logic        exp_ready;
        logic [31:0] exp_pc;
        logic [31:0] exp_plus4;
        logic [15:0] exp_stall;
    } vec_t;

    vec_t vecs[16];

    if_id_stage_buffer #(.DATA_W(32)) dut (
        .clk             (clk),
        .reset           (reset),
        .in_valid        (in_valid),
        .in_ready        (in_ready),
        .in_instruction  (in_instruction),
        .in_pc           (in_pc),
        .flush           (flush),
        .out_valid       (out_valid),
        .out_ready       (out_ready),
        .out_instruction (out_instruction),
        .out_pc          (out_pc),
        .out_pc_plus4    (out_pc_plus4),
        .out_opcode      (out_opcode),
        .out_rs          (out_rs),
        .out_rt          (out_rt),
        .out_rd          (out_rd),
        .out_shamt       (out_shamt),
        .out_funct       (out_funct),
        .out_imm_sext    (out_imm_sext),
        .out_jump_target (out_jump_target),
        .stall_count     (stall_count)
    );

    // Free-running clock, rising edges at 5, 15, 25, ...
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Drive one cycle's inputs just after the falling edge, then settle.
    task automatic applyStimulus(input logic rst, input logic iv, input logic [31:0] instr,
                                 input logic [31:0] pc, input logic fl, input logic ordy);
        @(negedge clk);
        reset          = rst;
        in_valid       = iv;
        in_instruction = instr;
        in_pc          = pc;
        flush          = fl;
        out_ready      = ordy;
        #1;
    endtask

    // Reference model step at the rising edge: a bounded FIFO queue of depth two.
    task automatic advance();
        bit do_push;
        bit do_pop;
        @(posedge clk);
        if (reset) begin
            model_q.delete();
            model_stall = 0;
        end else if (flush) begin
            model_q.delete();
        end else begin
            do_push = in_valid && (model_q.size() < 2);
            do_pop  = (model_q.size() > 0) && out_ready;
            if (model_q.size() > 0 && !out_ready && model_stall < 32'hFFFF) model_stall++;
            if (do_pop) void'(model_q.pop_front());
            if (do_push) model_q.push_back('{instr: in_instruction, pc: in_pc});
        end
    endtask

    // Compare every output against what the model says the head should be.
    task automatic checkOutput();
        logic [31:0] e_instr;
        logic [31:0] e_pc;
        logic [31:0] e_plus4;
        logic        e_valid;
        e_valid = (model_q.size() > 0);
        e_instr = e_valid ? model_q[0].instr : 32'h0;
        e_pc    = e_valid ? model_q[0].pc : 32'h0;
        e_plus4 = e_valid ? e_pc + 32'd4 : 32'h0;
        cmp("out_valid", {31'h0, out_valid}, {31'h0, e_valid});
        cmp("in_ready", {31'h0, in_ready}, {31'h0, model_q.size() < 2});
        cmp("out_instruction", out_instruction, e_instr);
        cmp("out_pc", out_pc, e_pc);
        cmp("out_pc_plus4", out_pc_plus4, e_plus4);
        cmp("out_opcode", {26'h0, out_opcode}, e_instr >> 26);
        cmp("out_rs", {27'h0, out_rs}, (e_instr >> 21) & 32'h1F);
        cmp("out_rt", {27'h0, out_rt}, (e_instr >> 16) & 32'h1F);
        cmp("out_rd", {27'h0, out_rd}, (e_instr >> 11) & 32'h1F);
        cmp("out_shamt", {27'h0, out_shamt}, (e_instr >> 6) & 32'h1F);
        cmp("out_funct", {26'h0, out_funct}, e_instr & 32'h3F);
        cmp("out_imm_sext", out_imm_sext,
            (e_instr & 32'h8000) != 0 ? (32'hFFFF_0000 | (e_instr & 32'hFFFF)) : (e_instr & 32'hFFFF));
        cmp("out_jump_target", out_jump_target,
            e_valid ? ((e_plus4 & 32'hF000_0000) | ((e_instr & 32'h03FF_FFFF) << 2)) : 32'h0);
        cmp("stall_count", {16'h0, stall_count}, model_stall);
    endtask

    function automatic vec_t mk(logic iv, logic [31:0] instr, logic [31:0] pc, logic fl, logic ordy,
                                logic ev, logic er, logic [31:0] epc, logic [31:0] ep4, logic [15:0] est);
        vec_t v;
        v.rst = 1'b0; v.iv = iv; v.instr = instr; v.pc = pc; v.fl = fl; v.ordy = ordy;
        v.exp_valid = ev; v.exp_ready = er; v.exp_pc = epc; v.exp_plus4 = ep4; v.exp_stall = est;
        return v;
    endfunction

    initial begin
        reset = 1'b1; in_valid = 1'b0; in_instruction = '0; in_pc = '0; flush = 1'b0; out_ready = 1'b0;
        model_stall = 0;

        // Reset for two cycles; the second cycle already shows the reset state.
        applyStimulus(1, 1, 32'hDEAD_BEEF, 32'h1234, 0, 1);
        advance();
        applyStimulus(1, 1, 32'hDEAD_BEEF, 32'h1234, 1, 0);
        checkOutput();
        advance();

        // Directed table: expected values are the outputs seen during that row's cycle.
        vecs[0]  = mk(1, 32'h012A_4020, 32'h0,  0, 1,  0, 1, 32'h0,  32'h0,  16'd0);
        vecs[1]  = mk(0, 32'h0,         32'h0,  0, 1,  1, 1, 32'h0,  32'h4,  16'd0);
        vecs[2]  = mk(1, 32'h8C22_0004, 32'h0,  0, 0,  0, 1, 32'h0,  32'h0,  16'd0);
        vecs[3]  = mk(1, 32'hAC23_0008, 32'h4,  0, 0,  1, 1, 32'h0,  32'h4,  16'd0);
        vecs[4]  = mk(1, 32'h0000_0000, 32'h8,  0, 0,  1, 0, 32'h0,  32'h4,  16'd1);
        vecs[5]  = mk(0, 32'h0,         32'h0,  0, 1,  1, 0, 32'h0,  32'h4,  16'd2);
        vecs[6]  = mk(0, 32'h0,         32'h0,  0, 1,  1, 1, 32'h4,  32'h8,  16'd2);
        vecs[7]  = mk(1, 32'h1111_1111, 32'h10, 0, 0,  0, 1, 32'h0,  32'h0,  16'd2);
        vecs[8]  = mk(1, 32'h2222_2222, 32'h8,  0, 1,  1, 1, 32'h10, 32'h14, 16'd2);
        vecs[9]  = mk(0, 32'h0,         32'h0,  0, 0,  1, 1, 32'h8,  32'hC,  16'd2);
        vecs[10] = mk(1, 32'h3333_3333, 32'hC,  0, 0,  1, 1, 32'h8,  32'hC,  16'd3);
        vecs[11] = mk(1, 32'h4444_4444, 32'h20, 1, 0,  1, 0, 32'h8,  32'hC,  16'd4);
        vecs[12] = mk(0, 32'h0,         32'h0,  0, 0,  0, 1, 32'h0,  32'h0,  16'd4);
        vecs[13] = mk(1, 32'h2008_FFFC, 32'hFFFF_FFFC, 0, 0, 0, 1, 32'h0, 32'h0, 16'd4);
        vecs[14] = mk(0, 32'h0,         32'h0,  0, 1,  1, 1, 32'hFFFF_FFFC, 32'h0, 16'd4);
        vecs[15] = mk(0, 32'h0,         32'h0,  0, 0,  0, 1, 32'h0,  32'h0,  16'd4);

        for (int i = 0; i < 16; i++) begin
            applyStimulus(vecs[i].rst, vecs[i].iv, vecs[i].instr, vecs[i].pc, vecs[i].fl, vecs[i].ordy);
            cmp($sformatf("vec%0d.out_valid", i), {31'h0, out_valid}, {31'h0, vecs[i].exp_valid});
            cmp($sformatf("vec%0d.in_ready", i), {31'h0, in_ready}, {31'h0, vecs[i].exp_ready});
            cmp($sformatf("vec%0d.out_pc", i), out_pc, vecs[i].exp_pc);
            cmp($sformatf("vec%0d.out_pc_plus4", i), out_pc_plus4, vecs[i].exp_plus4);
            cmp($sformatf("vec%0d.stall_count", i), {16'h0, stall_count}, {16'h0, vecs[i].exp_stall});
            checkOutput();
            advance();
        end

        // R-type field decode of 0x012A4020 (add $8,$9,$10).
        applyStimulus(0, 1, 32'h012A_4020, 32'h100, 0, 1);
        advance();
        applyStimulus(0, 0, 32'h0, 32'h0, 0, 1);
        cmp("rtype.opcode", {26'h0, out_opcode}, 32'd0);
        cmp("rtype.rs", {27'h0, out_rs}, 32'd9);
        cmp("rtype.rt", {27'h0, out_rt}, 32'd10);
        cmp("rtype.rd", {27'h0, out_rd}, 32'd8);
        cmp("rtype.funct", {26'h0, out_funct}, 32'h20);
        checkOutput();
        advance();

        // PC wrap, negative immediate and jump target from the top of the address space.
        applyStimulus(0, 1, 32'h2008_FFFC, 32'hFFFF_FFFC, 0, 0);
        advance();
        applyStimulus(0, 0, 32'h0, 32'h0, 0, 1);
        cmp("wrap.imm_sext", out_imm_sext, 32'hFFFF_FFFC);
        cmp("wrap.pc_plus4", out_pc_plus4, 32'h0);
        cmp("wrap.jump_target", out_jump_target, 32'h0023_FFF0);
        advance();

        // Reset in the middle of a full buffer, with a flush and a push alongside it.
        applyStimulus(0, 1, 32'hAAAA_0001, 32'h30, 0, 0);
        advance();
        applyStimulus(0, 1, 32'hAAAA_0002, 32'h34, 0, 0);
        advance();
        applyStimulus(1, 1, 32'hAAAA_0003, 32'h38, 1, 1);
        advance();
        applyStimulus(0, 1, 32'hBBBB_0000, 32'h40, 0, 0);
        cmp("midreset.out_valid", {31'h0, out_valid}, 32'd0);
        cmp("midreset.stall_count", {16'h0, stall_count}, 32'd0);
        advance();
        applyStimulus(0, 0, 32'h0, 32'h0, 0, 1);
        cmp("midreset.first_pc", out_pc, 32'h40);
        checkOutput();
        advance();

        // Random traffic against the reference model.
        for (int i = 0; i < 2000; i++) begin
            applyStimulus(($urandom % 64) == 0, ($urandom % 3) != 0, $urandom, $urandom & 32'hFFFF_FFFC,
                          ($urandom % 16) == 0, ($urandom % 2) == 1);
            checkOutput();
            advance();
        end

        // Long stall until the counter saturates, then reset clears it.
        applyStimulus(1, 0, 32'h0, 32'h0, 0, 0);
        advance();
        applyStimulus(0, 1, 32'hCCCC_0000, 32'h50, 0, 0);
        advance();
        for (int i = 0; i < 70000; i++) begin
            applyStimulus(0, 0, 32'h0, 32'h0, 0, 0);
            advance();
        end
        applyStimulus(0, 0, 32'h0, 32'h0, 0, 0);
        cmp("sat.stall_count", {16'h0, stall_count}, 32'hFFFF);
        cmp("sat.out_pc", out_pc, 32'h50);
        checkOutput();
        advance();
        applyStimulus(1, 0, 32'h0, 32'h0, 0, 0);
        advance();
        applyStimulus(0, 0, 32'h0, 32'h0, 0, 0);
        cmp("sat_reset.stall_count", {16'h0, stall_count}, 32'd0);
        cmp("sat_reset.out_valid", {31'h0, out_valid}, 32'd0);
        cmp("sat_reset.in_ready", {31'h0, in_ready}, 32'd1);
        checkOutput();
        advance();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
